keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner for a ROWS×COLS active-high key matrix. It drives one column at a time and samples the synchronised row lines. Each full sweep is reduced to a frame result: no key, one key, or several keys. A frame result is committed only after it has been identical for DEBOUNCE consecutive frames. The block sits between the keypad pins and the command/operand logic and replaces the fixed 4×4 scanner, adding debounce, release and multi-key reporting, and arbitrary matrix size.

---
 rtl/keypad_pkg.sv | 31 +++
 rtl/keypad_debounce.sv | 103 ++++++++++
 rtl/keypad_scanner.sv | 111 +++++++++++
 tb/tb_keypad_scanner.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and parameter checks for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_MULTI
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_SINGLE,
        RES_MULTI
    } kind_t;

    function automatic bit params_ok(
        input int rows,
        input int cols,
        input int scan_div,
        input int debounce
    );
        return (rows >= 2) && (rows <= 8) &&
               (cols >= 2) && (cols <= 8) &&
               (scan_div >= 3) && (debounce >= 1);
    endfunction

    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-result debouncer and committed-state FSM with output pulses.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE = 3,
    parameter int CODE_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_end,
    input  logic [1:0]        kind,
    input  logic [CODE_W-1:0] code,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_held,
    output logic              multi_key
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        prev_kind;
    logic [CODE_W-1:0] prev_code;
    logic [CNT_W-1:0]  stable_cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [CODE_W-1:0] code_nx;
    logic              valid_nx;
    logic              release_nx;
    logic              same;
    logic              differs;

    always_comb begin
        same = (kind == prev_kind) &&
               ((kind != RES_SINGLE) || (code == prev_code));
        if (!same)
            cnt_nx = CNT_W'(1);
        else if (stable_cnt == CNT_W'(DEBOUNCE))
            cnt_nx = stable_cnt;
        else
            cnt_nx = stable_cnt + CNT_W'(1);
    end

    // A frame result "differs" when committing it would change what is reported.
    always_comb begin
        differs = 1'b0;
        case (state)
            ST_IDLE:    differs = (kind != RES_NONE);
            ST_PRESSED: differs = (kind != RES_SINGLE) || (code != key_code);
            default:    differs = (kind != RES_MULTI);
        endcase
    end

    always_comb begin
        state_nx   = state;
        code_nx    = key_code;
        valid_nx   = 1'b0;
        release_nx = 1'b0;
        if (frame_end && (cnt_nx == CNT_W'(DEBOUNCE)) && differs) begin
            case (kind)
                RES_SINGLE: begin
                    state_nx = ST_PRESSED;
                    code_nx  = code;
                    valid_nx = 1'b1;
                end
                RES_MULTI: begin
                    state_nx = ST_MULTI;
                end
                default: begin
                    state_nx   = ST_IDLE;
                    release_nx = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            prev_kind   <= RES_NONE;
            prev_code   <= '0;
            stable_cnt  <= '0;
        end else begin
            state       <= state_nx;
            key_code    <= code_nx;
            key_valid   <= valid_nx;
            key_release <= release_nx;
            if (frame_end) begin
                prev_kind  <= kind;
                prev_code  <= code;
                stable_cnt <= cnt_nx;
            end
        end
    end

    assign key_held  = (state == ST_PRESSED);
    assign multi_key = (state == ST_MULTI);

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad front end: row synchroniser, scan counters and
// per-frame accumulator feeding the debouncer.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 4,
    parameter int DEBOUNCE = 3,
    parameter int CODE_W   = code_width(ROWS, COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   fila,
    output logic [COLS-1:0]   col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_held,
    output logic              multi_key
);

    localparam int N     = ROWS * COLS;
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int COL_W = $clog2(COLS);

    if (!params_ok(ROWS, COLS, SCAN_DIV, DEBOUNCE)) begin : g_bad_params
        $error("keypad_scanner: parameter out of range");
    end

    logic [ROWS-1:0]   sync1;
    logic [ROWS-1:0]   sync2;
    logic [DIV_W-1:0]  dwell;
    logic [COL_W-1:0]  col_idx;
    logic [N-1:0]      acc;
    logic [N-1:0]      frame_bits;
    logic              sample;
    logic              frame_end;
    logic [1:0]        hits;
    kind_t             kind;
    logic [CODE_W-1:0] code;

    assign sample    = (dwell == DIV_W'(SCAN_DIV - 1));
    assign frame_end = sample && (col_idx == COL_W'(COLS - 1));
    assign col       = COLS'(1) << col_idx;

    // Merge the current column's rows so the last column lands in this frame.
    always_comb begin
        frame_bits = acc;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (col_idx == COL_W'(c))
                    frame_bits[r*COLS + c] = sync2[r];
            end
        end
    end

    always_comb begin
        hits = 2'd0;
        code = '0;
        for (int i = 0; i < N; i++) begin
            if (frame_bits[i]) begin
                if (hits != 2'd2)
                    hits = hits + 2'd1;
                code = CODE_W'(i);
            end
        end
        unique case (1'b1)
            hits == 2'd0: kind = RES_NONE;
            hits == 2'd1: kind = RES_SINGLE;
            default:      kind = RES_MULTI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            dwell   <= '0;
            col_idx <= '0;
            acc     <= '0;
        end else begin
            sync1 <= fila;
            sync2 <= sync1;
            if (sample) begin
                dwell   <= '0;
                col_idx <= frame_end ? '0 : col_idx + COL_W'(1);
                acc     <= frame_end ? '0 : frame_bits;
            end else begin
                dwell <= dwell + DIV_W'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE(DEBOUNCE),
        .CODE_W  (CODE_W)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_end  (frame_end),
        .kind       (kind),
        .code       (code),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_release(key_release),
        .key_held   (key_held),
        .multi_key  (multi_key)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 and a 3x5 instance against a frame-level model.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] fila0, col0, code0;
    logic [2:0] fila1;
    logic [4:0] col1;
    logic [3:0] code1;
    logic       v0, r0, h0, m0;
    logic       v1, r1, h1, m1;

    bit pk  [2][8][8];
    bit rec [2][8][8];
    int hist [2][8];
    int nh [2], com [2], ecode [2], nval [2], nrel [2];
    bit ev [2], er [2];
    int cyc;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        fila0 = '0;
        fila1 = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pk[0][r][c] && col0[c]) fila0[r] = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                if (pk[1][r][c] && col1[c]) fila1[r] = 1'b1;
    end

    keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(SD), .DEBOUNCE(DB)) u0 (
        .clk(clk), .rst_n(rst_n), .fila(fila0), .col(col0),
        .key_code(code0), .key_valid(v0), .key_release(r0),
        .key_held(h0), .multi_key(m0)
    );

    keypad_scanner #(.ROWS(3), .COLS(5), .SCAN_DIV(SD), .DEBOUNCE(DB)) u1 (
        .clk(clk), .rst_n(rst_n), .fila(fila1), .col(col1),
        .key_code(code1), .key_valid(v1), .key_release(r1),
        .key_held(h1), .multi_key(m1)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    function automatic int ncols(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    function automatic int nrows(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            com[i] = -1;
            ecode[i] = 0;
            nh[i] = 0;
            ev[i] = 0;
            er[i] = 0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) rec[i][r][c] = 0;
        end
    endtask

    // Frame result: -1 none, -2 several keys, else row*COLS+col.
    task automatic step(input int i);
        int nc, nr, j, res, hits, cc;
        bit stable;
        logic [7:0] ocol;
        logic [3:0] oc;
        logic v, rl, h, m;
        nc = ncols(i);
        nr = nrows(i);
        j = cyc;
        ev[i] = 0;
        er[i] = 0;
        if (j > 0 && j % SD == 0 && (j / SD) % nc == 0) begin
            hits = 0;
            res = -1;
            for (int r = 0; r < nr; r++)
                for (int c = 0; c < nc; c++)
                    if (rec[i][r][c]) begin
                        hits++;
                        res = r * nc + c;
                        rec[i][r][c] = 0;
                    end
            if (hits > 1) res = -2;
            for (int k = DB - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = res;
            if (nh[i] < DB) nh[i]++;
            stable = (nh[i] == DB);
            for (int k = 0; k < DB; k++)
                if (hist[i][k] != res) stable = 0;
            if (stable && res != com[i]) begin
                if (res >= 0) begin
                    ev[i] = 1;
                    ecode[i] = res;
                end else if (res == -1) begin
                    er[i] = 1;
                end
                com[i] = res;
            end
        end
        cc = (j / SD) % nc;
        if (j % SD == SD / 2)
            for (int r = 0; r < nr; r++) rec[i][r][cc] = pk[i][r][cc];
        if (i == 0) begin
            ocol = 8'(col0); v = v0; rl = r0; h = h0; m = m0; oc = code0;
        end else begin
            ocol = 8'(col1); v = v1; rl = r1; h = h1; m = m1; oc = code1;
        end
        chk($sformatf("col%0d", i), int'(ocol), 1 << cc);
        chk($sformatf("out%0d", i), int'({v, rl, h, m, oc}),
            int'({ev[i], er[i], com[i] >= 0, com[i] == -2, 4'(ecode[i])}));
        if (v)  nval[i]++;
        if (rl) nrel[i]++;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            step(0);
            step(1);
        end
    end

    task automatic tick_col(input int n);
        repeat (n) begin
            do begin
                @(posedge clk);
                #1;
            end while (cyc % SD != 0);
        end
    endtask

    task automatic wait_frames(input int i, input int n);
        repeat (n) begin
            do begin
                @(posedge clk);
                #1;
            end while (cyc % (SD * ncols(i)) != 0);
        end
    endtask

    task automatic wait_valid(input int i, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk);
            #1;
            if ((i == 0) ? v0 : v1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic clear(input int i);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) pk[i][r][c] = 0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_col0", int'(col0), 1);
        chk("rst_out0", int'({v0, r0, h0, m0, code0}), 0);
        chk("rst_col1", int'(col1), 1);
        chk("rst_out1", int'({v1, r1, h1, m1, code1}), 0);
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, bv, br, ii, kk, rr, cc2;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_frames(0, 2);
        tick_col($urandom_range(1, 3));
        do_reset(2);
        repeat (4) @(posedge clk);
        #1 chk("col_step", int'(col0), 2);
        repeat (12) @(posedge clk);
        #1 chk("col_wrap", int'(col0), 1);

        tick_col($urandom_range(0, 7));
        bv = nval[0];
        br = nrel[0];
        pk[0][2][1] = 1;
        wait_valid(0, 67, n);
        chk("lat9_ok", int'(n > 0), 1);
        chk("code9", int'(code0), 9);
        chk("held9", int'(h0), 1);
        wait_frames(0, 4);
        chk("once9", nval[0] - bv, 1);
        clear(0);
        wait_frames(0, 5);
        chk("rel9", nrel[0] - br, 1);
        chk("keep9", int'(code0), 9);

        bv = nval[0];
        br = nrel[0];
        tick_col($urandom_range(0, 3));
        for (int t = 0; t < 12; t++) begin
            pk[0][1][1] = ~pk[0][1][1];
            tick_col(3);
        end
        chk("bounce_quiet", nval[0] - bv, 0);
        pk[0][1][1] = 1;
        wait_valid(0, 67, n);
        chk("bounce_ok", int'(n > 0), 1);
        wait_frames(0, 4);
        chk("bounce_once", nval[0] - bv, 1);
        chk("bounce_code", int'(code0), 5);
        clear(0);
        wait_frames(0, 5);

        bv = nval[0];
        br = nrel[0];
        pk[0][0][0] = 1;
        pk[0][1][1] = 1;
        wait_frames(0, 5);
        chk("multi_on", int'(m0), 1);
        chk("multi_held", int'(h0), 0);
        chk("multi_noval", nval[0] - bv, 0);
        chk("multi_code", int'(code0), 5);
        clear(0);
        wait_frames(0, 5);
        chk("multi_rel", nrel[0] - br, 1);
        chk("multi_off", int'(m0), 0);

        bv = nval[0];
        br = nrel[0];
        pk[0][0][3] = 1;
        wait_frames(0, 5);
        chk("roll3", int'(code0), 3);
        pk[0][0][3] = 0;
        pk[0][3][0] = 1;
        wait_frames(0, 5);
        chk("roll12", int'(code0), 12);
        chk("roll_val", nval[0] - bv, 2);
        chk("roll_norel", nrel[0] - br, 0);
        clear(0);
        wait_frames(0, 5);

        pk[0][1][3] = 1;
        wait_frames(0, 2);
        tick_col(1);
        bv = nval[0];
        do_reset(3);
        wait_valid(0, 100, n);
        chk("rst_relat", n, 48);
        wait_frames(0, 2);
        chk("rst_once", nval[0] - bv, 1);
        chk("rst_code", int'(code0), 7);
        clear(0);
        wait_frames(0, 5);

        wait_frames(1, 1);
        for (int k = 0; k < 5; k++) begin
            chk("ns_col", int'(col1), 1 << k);
            tick_col(1);
        end
        wait_frames(1, 1);
        bv = nval[1];
        pk[1][2][4] = 1;
        wait_valid(1, 83, n);
        chk("ns_ok", int'(n > 0), 1);
        chk("ns_code", int'(code1), 14);
        wait_frames(1, 2);
        chk("ns_once", nval[1] - bv, 1);
        clear(1);
        wait_frames(1, 5);
        chk("ns_rel", int'(h1), 0);

        for (int it = 0; it < 40; it++) begin
            ii = $urandom_range(0, 1);
            kk = $urandom_range(0, 3);
            tick_col($urandom_range(0, 6));
            if (kk != 3) clear(ii);
            if (kk == 1 || kk == 2) begin
                rr = $urandom_range(0, nrows(ii) - 1);
                cc2 = $urandom_range(0, ncols(ii) - 1);
                pk[ii][rr][cc2] = 1;
            end
            if (kk == 2) begin
                rr = $urandom_range(0, nrows(ii) - 1);
                cc2 = $urandom_range(0, ncols(ii) - 1);
                pk[ii][rr][cc2] = 1;
            end
            if ($urandom_range(0, 9) == 0) do_reset(2);
            tick_col($urandom_range(2, 24));
        end

        clear(0);
        clear(1);
        wait_frames(1, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
